// File: rtl/eth_rx_ctrl.sv
// -----------------------------------------------------------------------------
// eth_rx_pkg / eth_rx_ctrl
//
// RMII (2-bit) Ethernet receive controller. It hunts for a preamble and SFD,
// reassembles bytes from dibits, filters on destination address, keeps a
// running CRC-32 and reports the frame status once per frame.
//
// Parameters
//   pMAC_ADDR         station unicast address, byte 0 (MSB) first on the wire
//   pMAX_FRAME_BYTES  largest legal frame, DEST_ADDR through FCS
//   pMIN_FRAME_BYTES  smallest legal frame, DEST_ADDR through FCS
//
// Ports
//   Clk               50 MHz RMII reference clock
//   Rst               synchronous, active-high reset
//   Rx_Dv             RMII CRS_DV
//   Rxd[1:0]          RMII receive dibit, bit 0 earliest on the wire
//   Byte_Vld          one-cycle strobe, Byte_Data valid
//   Byte_Data[7:0]    received byte (DEST_ADDR through FCS)
//   Byte_Sof          with Byte_Vld on the first DEST_ADDR byte
//   Frame_Done        one-cycle end-of-frame strobe
//   Frame_Ok          no error flag set (valid with Frame_Done)
//   Crc_Err           FCS check failed
//   Len_Err           frame too short or too long
//   Addr_Err          destination address not accepted
//   Align_Err         frame ended on a partial byte
//   Rx_Ctrl_FSM_State current controller state
//
// The status flags are held from Frame_Done until the next SFD.
// -----------------------------------------------------------------------------
package eth_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREAMBLE  = 3'd1,
        DEST_ADDR = 3'd2,
        SRC_ADDR  = 3'd3,
        LEN_TYPE  = 3'd4,
        DATA      = 3'd5,
        DROP      = 3'd6
    } eth_rx_ctrl_state_t;

endpackage

module eth_rx_ctrl
    import eth_rx_pkg::*;
#(
    parameter logic [47:0] pMAC_ADDR        = 48'h02_00_00_00_00_01,
    parameter int          pMAX_FRAME_BYTES = 1518,
    parameter int          pMIN_FRAME_BYTES = 64
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Rx_Dv,
    input  logic [1:0]         Rxd,
    output logic               Byte_Vld,
    output logic [7:0]         Byte_Data,
    output logic               Byte_Sof,
    output logic               Frame_Done,
    output logic               Frame_Ok,
    output logic               Crc_Err,
    output logic               Len_Err,
    output logic               Addr_Err,
    output logic               Align_Err,
    output eth_rx_ctrl_state_t Rx_Ctrl_FSM_State
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    // Register value left behind after running a correct FCS through the CRC.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MAX_P1      = 11'(pMAX_FRAME_BYTES + 1);
    localparam logic [10:0] MIN_LEN     = 11'(pMIN_FRAME_BYTES);
    localparam logic [10:0] END_DEST    = 11'd6;
    localparam logic [10:0] END_SRC     = 11'd12;
    localparam logic [10:0] END_LEN     = 11'd14;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    eth_rx_ctrl_state_t state_reg, state_next;
    logic [1:0]  dibit_cnt_reg, dibit_cnt_next;
    logic [5:0]  shift_reg, shift_next;      // three most recent dibits
    logic [10:0] byte_cnt_reg, byte_cnt_next;
    logic [31:0] crc_reg, crc_next;
    logic [39:0] dest_reg, dest_next;        // first five DEST_ADDR bytes
    logic        addr_pend_reg, addr_pend_next;
    logic        len_pend_reg, len_pend_next;
    logic        report_reg, report_next;    // DROP must finish with Frame_Done

    logic        byte_vld_reg, byte_vld_next;
    logic [7:0]  byte_data_reg, byte_data_next;
    logic        byte_sof_reg, byte_sof_next;
    logic        frame_done_reg, frame_done_next;
    logic        frame_ok_reg, frame_ok_next;
    logic        crc_err_reg, crc_err_next;
    logic        len_err_reg, len_err_next;
    logic        addr_err_reg, addr_err_next;
    logic        align_err_reg, align_err_next;

    // ------------------------------------------------------------------
    // Byte assembly helpers
    // ------------------------------------------------------------------
    logic [7:0]  assembled;      // byte completed by the current dibit
    logic [47:0] dest_cand;      // full destination if this is byte 6
    logic [5:0]  byte_is_mac;
    logic [5:0]  byte_is_bcast;
    logic        addr_match;
    logic [10:0] byte_cnt_inc;
    logic        byte_done;

    // Dibits arrive LSB first, so the newest dibit lands in the top bits.
    assign assembled    = {Rxd, shift_reg};
    assign dest_cand    = {dest_reg, assembled};
    assign byte_cnt_inc = byte_cnt_reg + 11'd1;
    assign byte_done    = (dibit_cnt_reg == 2'd3);

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_addr_cmp
            assign byte_is_mac[gi]   = (dest_cand[8*gi +: 8] == pMAC_ADDR[8*gi +: 8]);
            assign byte_is_bcast[gi] = (dest_cand[8*gi +: 8] == 8'hFF);
        end
    endgenerate

    assign addr_match = (&byte_is_mac) | (&byte_is_bcast);

    // Reflected CRC-32, one byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        dibit_cnt_next  = dibit_cnt_reg;
        shift_next      = shift_reg;
        byte_cnt_next   = byte_cnt_reg;
        crc_next        = crc_reg;
        dest_next       = dest_reg;
        addr_pend_next  = addr_pend_reg;
        len_pend_next   = len_pend_reg;
        report_next     = report_reg;
        byte_vld_next   = 1'b0;
        byte_data_next  = byte_data_reg;
        byte_sof_next   = 1'b0;
        frame_done_next = 1'b0;
        frame_ok_next   = frame_ok_reg;
        crc_err_next    = crc_err_reg;
        len_err_next    = len_err_reg;
        addr_err_next   = addr_err_reg;
        align_err_next  = align_err_reg;

        case (state_reg)
            IDLE: begin
                if (Rx_Dv && (Rxd == 2'b01)) begin
                    state_next = PREAMBLE;
                end
            end

            PREAMBLE: begin
                if (!Rx_Dv) begin
                    state_next = IDLE;
                end else begin
                    case (Rxd)
                        2'b01: state_next = PREAMBLE;
                        2'b11: begin
                            // SFD complete: fresh frame, previous status released.
                            state_next     = DEST_ADDR;
                            dibit_cnt_next = 2'd0;
                            shift_next     = 6'd0;
                            byte_cnt_next  = 11'd0;
                            crc_next       = CRC_INIT;
                            dest_next      = 40'd0;
                            addr_pend_next = 1'b0;
                            len_pend_next  = 1'b0;
                            report_next    = 1'b0;
                            frame_ok_next  = 1'b0;
                            crc_err_next   = 1'b0;
                            len_err_next   = 1'b0;
                            addr_err_next  = 1'b0;
                            align_err_next = 1'b0;
                        end
                        default: begin
                            // Broken preamble: swallow the burst silently.
                            state_next  = DROP;
                            report_next = 1'b0;
                        end
                    endcase
                end
            end

            DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA: begin
                if (!Rx_Dv) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                    align_err_next  = (dibit_cnt_reg != 2'd0);
                    len_err_next    = (byte_cnt_reg < MIN_LEN);
                    crc_err_next    = (crc_reg != CRC_RESIDUE);
                    addr_err_next   = 1'b0;
                    frame_ok_next   = (dibit_cnt_reg == 2'd0) &&
                                      (byte_cnt_reg >= MIN_LEN) &&
                                      (crc_reg == CRC_RESIDUE);
                end else begin
                    dibit_cnt_next = dibit_cnt_reg + 2'd1;
                    shift_next     = assembled[7:2];
                    if (byte_done) begin
                        byte_cnt_next = byte_cnt_inc;
                        if (byte_cnt_inc == MAX_P1) begin
                            // Oversize: the offending byte is not forwarded.
                            len_pend_next = 1'b1;
                            report_next   = 1'b1;
                            state_next    = DROP;
                        end else begin
                            byte_vld_next  = 1'b1;
                            byte_data_next = assembled;
                            byte_sof_next  = (byte_cnt_inc == 11'd1);
                            crc_next       = crc32_byte(crc_reg, assembled);
                            case (state_reg)
                                DEST_ADDR: begin
                                    dest_next = dest_cand[39:0];
                                    if (byte_cnt_inc == END_DEST) begin
                                        if (addr_match) begin
                                            state_next = SRC_ADDR;
                                        end else begin
                                            addr_pend_next = 1'b1;
                                            report_next    = 1'b1;
                                            state_next     = DROP;
                                        end
                                    end
                                end
                                SRC_ADDR: begin
                                    if (byte_cnt_inc == END_SRC) begin
                                        state_next = LEN_TYPE;
                                    end
                                end
                                LEN_TYPE: begin
                                    if (byte_cnt_inc == END_LEN) begin
                                        state_next = DATA;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            end

            DROP: begin
                if (!Rx_Dv) begin
                    state_next = IDLE;
                    if (report_reg) begin
                        frame_done_next = 1'b1;
                        frame_ok_next   = 1'b0;
                        crc_err_next    = 1'b0;
                        align_err_next  = 1'b0;
                        addr_err_next   = addr_pend_reg;
                        len_err_next    = len_pend_reg;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg      <= IDLE;
            dibit_cnt_reg  <= 2'd0;
            shift_reg      <= 6'd0;
            byte_cnt_reg   <= 11'd0;
            crc_reg        <= CRC_INIT;
            dest_reg       <= 40'd0;
            addr_pend_reg  <= 1'b0;
            len_pend_reg   <= 1'b0;
            report_reg     <= 1'b0;
            byte_vld_reg   <= 1'b0;
            byte_data_reg  <= 8'd0;
            byte_sof_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_ok_reg   <= 1'b0;
            crc_err_reg    <= 1'b0;
            len_err_reg    <= 1'b0;
            addr_err_reg   <= 1'b0;
            align_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dibit_cnt_reg  <= dibit_cnt_next;
            shift_reg      <= shift_next;
            byte_cnt_reg   <= byte_cnt_next;
            crc_reg        <= crc_next;
            dest_reg       <= dest_next;
            addr_pend_reg  <= addr_pend_next;
            len_pend_reg   <= len_pend_next;
            report_reg     <= report_next;
            byte_vld_reg   <= byte_vld_next;
            byte_data_reg  <= byte_data_next;
            byte_sof_reg   <= byte_sof_next;
            frame_done_reg <= frame_done_next;
            frame_ok_reg   <= frame_ok_next;
            crc_err_reg    <= crc_err_next;
            len_err_reg    <= len_err_next;
            addr_err_reg   <= addr_err_next;
            align_err_reg  <= align_err_next;
        end
    end

    assign Byte_Vld          = byte_vld_reg;
    assign Byte_Data         = byte_data_reg;
    assign Byte_Sof          = byte_sof_reg;
    assign Frame_Done        = frame_done_reg;
    assign Frame_Ok          = frame_ok_reg;
    assign Crc_Err           = crc_err_reg;
    assign Len_Err           = len_err_reg;
    assign Addr_Err          = addr_err_reg;
    assign Align_Err         = align_err_reg;
    assign Rx_Ctrl_FSM_State = state_reg;

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_ctrl
//
// Scoreboard bench for eth_rx_ctrl. Each frame is built in a byte queue, a
// frame-level reference model predicts the bytes and status the receiver
// must produce, and a negedge monitor pops and compares as outputs appear.
// -----------------------------------------------------------------------------
module tb_eth_rx_ctrl;
    import eth_rx_pkg::*;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam int          MAX_B = 1518;
    localparam int          MIN_B = 64;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic               Rx_Dv = 1'b0;
    logic [1:0]         Rxd = 2'b00;
    logic               Byte_Vld;
    logic [7:0]         Byte_Data;
    logic               Byte_Sof;
    logic               Frame_Done;
    logic               Frame_Ok;
    logic               Crc_Err;
    logic               Len_Err;
    logic               Addr_Err;
    logic               Align_Err;
    eth_rx_ctrl_state_t Rx_Ctrl_FSM_State;

    eth_rx_ctrl #(
        .pMAC_ADDR       (MAC),
        .pMAX_FRAME_BYTES(MAX_B),
        .pMIN_FRAME_BYTES(MIN_B)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Rx_Dv            (Rx_Dv),
        .Rxd              (Rxd),
        .Byte_Vld         (Byte_Vld),
        .Byte_Data        (Byte_Data),
        .Byte_Sof         (Byte_Sof),
        .Frame_Done       (Frame_Done),
        .Frame_Ok         (Frame_Ok),
        .Crc_Err          (Crc_Err),
        .Len_Err          (Len_Err),
        .Addr_Err         (Addr_Err),
        .Align_Err        (Align_Err),
        .Rx_Ctrl_FSM_State(Rx_Ctrl_FSM_State)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
    } exp_byte_t;

    // Order matches {Frame_Ok, Crc_Err, Len_Err, Addr_Err, Align_Err}.
    typedef struct packed {
        logic ok;
        logic crc;
        logic len;
        logic addr;
        logic align;
    } exp_res_t;

    exp_byte_t  exp_bytes[$];
    exp_res_t   exp_res[$];
    logic [7:0] frame[$];
    exp_res_t   hold_exp = '0;
    int         checks = 0;
    int         errors = 0;
    int         out_count = 0;
    int         frame_no = 0;
    logic       prev_vld = 1'b0;
    logic       prev_done = 1'b0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk(act === exp, name, act, exp);
    endtask

    function automatic logic [4:0] flags_now();
        return {Frame_Ok, Crc_Err, Len_Err, Addr_Err, Align_Err};
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge Clk) begin
        exp_byte_t eb;
        exp_res_t  er;
        if (Byte_Sof) chk_eq("sof_needs_vld", Byte_Vld, 1);
        if (Byte_Vld) begin
            out_count++;
            chk_eq("vld_single_cycle", prev_vld, 0);
            chk(exp_bytes.size() > 0, "unexpected_byte", Byte_Data, 0);
            if (exp_bytes.size() > 0) begin
                eb = exp_bytes.pop_front();
                chk_eq("byte_data", Byte_Data, eb.data);
                chk_eq("byte_sof", Byte_Sof, eb.sof);
            end
        end
        if (Frame_Done) begin
            out_count++;
            chk_eq("done_single_cycle", prev_done, 0);
            chk(exp_res.size() > 0, "unexpected_done", flags_now(), 0);
            if (exp_res.size() > 0) begin
                er = exp_res.pop_front();
                chk_eq("frame_flags", flags_now(), er);
            end
        end
        prev_vld  = Byte_Vld;
        prev_done = Frame_Done;
    end

    // ------------------------------------------------------------------
    // Frame construction
    // ------------------------------------------------------------------
    function automatic logic [31:0] fcs_of(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'd0, frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // kind: 0 broadcast, 1 own address, 2 02:00:00:00:00:02, 3 random
    task automatic build_frame(input int kind, input int n, input bit corrupt);
        logic [31:0] f;
        frame.delete();
        for (int i = 0; i < 6; i++) begin
            case (kind)
                0:       frame.push_back(8'hFF);
                1:       frame.push_back(8'(MAC >> (8 * (5 - i))));
                2:       frame.push_back((i == 5) ? 8'h02 : 8'(MAC >> (8 * (5 - i))));
                default: frame.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        for (int i = 6; i < n - 4; i++) frame.push_back(8'($urandom_range(0, 255)));
        f = fcs_of(n - 4);
        for (int i = 0; i < 4; i++) frame.push_back(8'(f >> (8 * i)));
        if (corrupt) frame[n - 1] = frame[n - 1] ^ 8'h01;
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame-level rules, pushed into the scoreboard
    // ------------------------------------------------------------------
    task automatic predict(input int extra, input bit bad_pre, input int rst_at);
        int        n;
        bit        is_bcast, is_mac, fcs_good;
        logic [31:0] fcs_rx;
        exp_res_t  r;
        n = frame.size();
        if (bad_pre) return;
        if (rst_at >= 0) begin
            for (int i = 0; i < rst_at; i++) exp_bytes.push_back({frame[i], i == 0});
            hold_exp = '0;
            return;
        end
        is_bcast = 1;
        is_mac   = 1;
        for (int i = 0; i < 6; i++) begin
            if (frame[i] != 8'hFF) is_bcast = 0;
            if (frame[i] != 8'(MAC >> (8 * (5 - i)))) is_mac = 0;
        end
        r = '0;
        if (!(is_bcast || is_mac)) begin
            for (int i = 0; i < 6; i++) exp_bytes.push_back({frame[i], i == 0});
            r.addr = 1;
        end else if (n > MAX_B) begin
            for (int i = 0; i < MAX_B; i++) exp_bytes.push_back({frame[i], i == 0});
            r.len = 1;
        end else begin
            for (int i = 0; i < n; i++) exp_bytes.push_back({frame[i], i == 0});
            fcs_rx   = {frame[n - 1], frame[n - 2], frame[n - 3], frame[n - 4]};
            fcs_good = (fcs_rx == fcs_of(n - 4));
            r.crc    = !fcs_good;
            r.len    = (n < MIN_B);
            r.align  = ((extra % 4) != 0);
            r.ok     = !(r.crc || r.len || r.align);
        end
        exp_res.push_back(r);
        hold_exp = r;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic dv, input logic [1:0] d);
        @(negedge Clk);
        Rx_Dv = dv;
        Rxd   = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) drive(1'b1, 2'(b >> (2 * k)));
    endtask

    task automatic run_frame(input string tag, input int extra, input bit bad_pre, input int rst_at);
        bit aborted;
        predict(extra, bad_pre, rst_at);
        $display("frame %0d: %s bytes=%0d extra_dibits=%0d bad_pre=%0d rst_at=%0d",
                 frame_no, tag, frame.size(), extra, bad_pre, rst_at);
        frame_no++;
        for (int i = 0; i < 7; i++) begin
            if (bad_pre && i == 2) begin
                drive(1'b1, 2'b01);
                drive(1'b1, 2'b10);
                drive(1'b1, 2'b01);
                drive(1'b1, 2'b01);
            end else begin
                send_byte(8'h55);
            end
        end
        send_byte(8'hD5);
        aborted = 0;
        for (int i = 0; i < frame.size(); i++) begin
            if (!aborted) begin
                if (i == rst_at) begin
                    @(negedge Clk);
                    Rst   = 1'b1;
                    Rx_Dv = 1'b1;
                    Rxd   = 2'(frame[i]);
                    @(negedge Clk);
                    chk_eq("rst_midframe_outputs",
                           {Rx_Ctrl_FSM_State, Byte_Vld, Byte_Sof, Frame_Done, flags_now()},
                           {IDLE, 3'b000, 5'b00000});
                    Rst   = 1'b0;
                    Rx_Dv = 1'b0;
                    Rxd   = 2'b00;
                    aborted = 1;
                end else begin
                    send_byte(frame[i]);
                end
            end
        end
        if (!aborted) begin
            for (int k = 0; k < extra; k++) drive(1'b1, 2'($urandom_range(0, 3)));
        end
        repeat (16) drive(1'b0, 2'b00);
        chk_eq("bytes_drained", exp_bytes.size(), 0);
        chk_eq("results_drained", exp_res.size(), 0);
        chk_eq("flags_hold", flags_now(), hold_exp);
        chk_eq("idle_after_frame", Rx_Ctrl_FSM_State, IDLE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        int kind, n, extra;
        bit corrupt;

        repeat (3) @(negedge Clk);
        chk_eq("reset_outputs",
               {Rx_Ctrl_FSM_State, Byte_Vld, Byte_Data, Byte_Sof, Frame_Done, flags_now()},
               {IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 5'b00000});
        Rst = 1'b0;
        repeat (4) drive(1'b0, 2'b00);

        // Carrier with all-zero dibits must never start anything.
        cnt0 = out_count;
        repeat (50) drive(1'b1, 2'b00);
        repeat (3) drive(1'b0, 2'b00);
        chk_eq("idle_rxd00_no_output", out_count - cnt0, 0);
        chk_eq("idle_rxd00_state", Rx_Ctrl_FSM_State, IDLE);

        build_frame(0, 64, 0);   run_frame("bcast64_good", 0, 0, -1);
        build_frame(0, 64, 1);   run_frame("bcast64_badfcs", 0, 0, -1);
        build_frame(2, 64, 0);   run_frame("unicast_other", 0, 0, -1);
        build_frame(1, 64, 0);   run_frame("unicast_own", 0, 0, -1);
        build_frame(0, 60, 0);   run_frame("short60", 0, 0, -1);
        build_frame(0, 18, 0);   run_frame("short18", 0, 0, -1);
        build_frame(0, 1518, 0); run_frame("max1518", 0, 0, -1);
        build_frame(0, 1519, 0); run_frame("over1519", 0, 0, -1);
        build_frame(0, 64, 0);   run_frame("align2", 2, 0, -1);
        build_frame(0, 64, 0);   run_frame("bad_preamble", 0, 1, -1);
        build_frame(0, 64, 0);   run_frame("reset_at_20", 0, 0, 20);
        build_frame(0, 64, 0);   run_frame("after_reset", 0, 0, -1);

        for (int t = 0; t < 25; t++) begin
            kind    = $urandom_range(0, 3);
            n       = $urandom_range(40, 130);
            corrupt = ($urandom_range(0, 3) == 0);
            extra   = $urandom_range(0, 5);
            if (extra > 3) extra = 0;
            build_frame(kind, n, corrupt);
            run_frame("random", extra, 0, -1);
        end

        repeat (5) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_ctrl.md
ETH_RX_CTRL -- requirements
Module: eth_rx_ctrl

Interface
REQ-001 SHALL have parameter pMAC_ADDR, default 48'h02_00_00_00_00_01, station unicast address (byte 0 = first on wire).
REQ-002 SHALL have parameter pMAX_FRAME_BYTES, default 1518, maximum byte count from DEST_ADDR through FCS.
REQ-003 SHALL have parameter pMIN_FRAME_BYTES, default 64, minimum byte count from DEST_ADDR through FCS.
REQ-004 Clk  input  1  50 MHz RMII reference clock.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 Rx_Dv  input  1  RMII CRS_DV, sampled on posedge Clk.
REQ-007 Rxd  input  2  RMII receive dibit, bit 0 earliest on wire.
REQ-008 Byte_Vld  output  1  one-cycle strobe, Byte_Data valid.
REQ-009 Byte_Data  output  8  received byte, DEST_ADDR through FCS inclusive.
REQ-010 Byte_Sof  output  1  high with Byte_Vld on first DEST_ADDR byte only.
REQ-011 Frame_Done  output  1  one-cycle end-of-frame strobe.
REQ-012 Frame_Ok  output  1  valid with Frame_Done: no error flags set.
REQ-013 Crc_Err, Len_Err, Addr_Err, Align_Err  output  1 each  valid with Frame_Done.
REQ-014 Rx_Ctrl_FSM_State  output  eth_rx_ctrl_state_t (eth_rx_pkg)  current state.

Function
REQ-015 States SHALL be IDLE, PREAMBLE, DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA, DROP.
REQ-016 IDLE: Rx_Dv=1 and Rxd=2'b01 -> PREAMBLE; Rxd=2'b00 or Rx_Dv=0 -> stay IDLE.
REQ-017 PREAMBLE: Rxd=01 -> stay; Rxd=11 (SFD end) -> DEST_ADDR, dibit/byte counters and CRC cleared; Rxd=00/10 -> DROP; Rx_Dv=0 -> IDLE, no Frame_Done.
REQ-018 Bytes SHALL assemble LSB-first from 4 dibits; Byte_Vld SHALL assert the cycle after the 4th dibit is sampled.
REQ-019 Byte counter SHALL be 11 bits, counting bytes emitted since SFD; DEST_ADDR->SRC_ADDR after 6, SRC_ADDR->LEN_TYPE after 12, LEN_TYPE->DATA after 14.
REQ-020 After the 6th DEST_ADDR byte, match = (dest == pMAC_ADDR) or (dest == 48'hFFFF_FFFF_FFFF); no match -> DROP with Addr_Err latched.
REQ-021 CRC-32 SHALL be computed reflected (poly 32'hEDB88320, init 32'hFFFFFFFF) over every byte DEST_ADDR through FCS; good frame iff final register = 32'hDEBB20E3.
REQ-022 Rx_Dv sampled low in DEST_ADDR..DATA SHALL end the frame: Frame_Done asserts the following cycle, FSM -> IDLE.
REQ-023 At end of frame: Align_Err if dibit count mod 4 != 0 (partial byte discarded); Len_Err if bytes < pMIN_FRAME_BYTES; Crc_Err per REQ-021; Frame_Ok = none set.
REQ-024 Byte count reaching pMAX_FRAME_BYTES+1 SHALL set Len_Err and -> DROP.
REQ-025 DROP: no Byte_Vld; stay until Rx_Dv=0; then -> IDLE and pulse Frame_Done (Frame_Ok=0, latched flags) only if DROP was entered from DEST_ADDR or later.
REQ-026 Error flags SHALL hold from Frame_Done until the next SFD; Frame_Done, Byte_Vld, Byte_Sof never high more than one cycle.
REQ-027 Rx_Dv high in IDLE with Rxd=00 for any duration SHALL NOT produce output.

Reset
REQ-028 Rst high SHALL force IDLE, counters/partial byte to 0, CRC to 32'hFFFFFFFF, all outputs 0, next cycle.
REQ-029 Rst mid-frame SHALL abandon the frame: no Frame_Done; after release, remaining dibits ignored until IDLE entry conditions recur.

Verification
REQ-030 Broadcast 64-byte frame, 7x55+D5 preamble, correct FCS -> 64 Byte_Vld, Byte_Sof on byte 0 (0xFF), Frame_Done with Frame_Ok=1.
REQ-031 Same frame, last FCS byte XOR 0x01 -> 64 bytes output, Frame_Done with Crc_Err=1, Frame_Ok=0.
REQ-032 Unicast to 02:00:00:00:00:02 -> 6 Byte_Vld then none, Frame_Done with Addr_Err=1.
REQ-033 60-byte frame with valid FCS -> Len_Err=1, Crc_Err=0; 1519-byte frame -> Len_Err=1, output stops at byte 1518.
REQ-034 Frame with 2 extra dibits before Rx_Dv falls -> Align_Err=1; preamble containing Rxd=10 -> DROP, no Frame_Done.
REQ-035 Rst pulse at byte 20 of valid frame -> no Frame_Done; next valid frame -> Frame_Ok=1.
